// File: rtl/priority_request_serializer.sv
// Priority request serializer: accepts a request vector and emits one beat per
// set bit in priority order, with rank, last-beat flag and population count.
module priority_request_serializer #(
  parameter int unsigned N         = 12,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_req,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_idx,
  output logic [$clog2(N)-1:0] out_rank,
  output logic                 out_last,
  output logic [$clog2(N):0]   out_count,
  output logic                 none_pulse
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam int          NI    = int'(N);
  localparam logic [N-1:0] ONE  = N'(1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [IDX_W-1:0] rank_q, rank_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;
  logic             none_q, none_d;

  // Index of the next request to grant: highest or lowest set bit.
  function automatic logic [IDX_W-1:0] pick(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < NI; i++) if (v[i]) r = IDX_W'(i);
    end else begin
      for (int i = NI - 1; i >= 0; i--) if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Number of set bits in a request vector.
  function automatic logic [IDX_W:0] popcnt(input logic [N-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < NI; i++) c = c + (IDX_W+1)'(v[i]);
    return c;
  endfunction

  // True when exactly one bit is set.
  function automatic logic single_bit(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - ONE)) == '0);
  endfunction

  // Next-state and next-output computation; the granted index and last flag
  // are precomputed from the next pending set so all beat outputs come from flops.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    rank_d    = rank_q;
    count_d   = count_q;
    none_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_req == '0) begin
            none_d = 1'b1;
          end else begin
            state_d   = EMIT;
            pending_d = in_req;
            rank_d    = '0;
            count_d   = popcnt(in_req);
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          pending_d = pending_q & ~(ONE << idx_q);
          if (last_q) begin
            state_d = IDLE;
            rank_d  = '0;
          end else begin
            rank_d = rank_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    idx_d  = pick(pending_d);
    last_d = single_bit(pending_d);
  end

  // State and output registers; reset wins over any accept or take.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      rank_q    <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rank_q    <= rank_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      none_q    <= none_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == EMIT);
  assign out_idx    = idx_q;
  assign out_rank   = rank_q;
  assign out_last   = last_q;
  assign out_count  = count_q;
  assign none_pulse = none_q;

endmodule

// File: tb/tb_priority_request_serializer.sv
// Scoreboard bench for priority_request_serializer across several widths and orders.
module tb_priority_request_serializer;

  localparam int NUM = 6;
  localparam int NS [NUM] = '{12, 12, 5, 5, 33, 33};
  localparam bit MS [NUM] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  typedef struct {
    int idx;
    int rank;
    bit last;
    int cnt;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  logic [NUM-1:0] in_valid, in_ready, out_valid, out_ready, out_last, none_pulse;
  logic [63:0] in_req [NUM];
  logic [7:0]  out_idx [NUM];
  logic [7:0]  out_rank [NUM];
  logic [7:0]  out_count [NUM];

  int errors = 0;
  int checks = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NUM; g++) begin : gd
    localparam int unsigned GN = NS[g];
    localparam int unsigned GW = $clog2(GN);
    logic [GW-1:0] idx, rank;
    logic [GW:0]   cnt;
    priority_request_serializer #(.N(GN), .MSB_FIRST(MS[g])) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_req    (in_req[g][GN-1:0]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_idx   (idx),
      .out_rank  (rank),
      .out_last  (out_last[g]),
      .out_count (cnt),
      .none_pulse(none_pulse[g])
    );
    assign out_idx[g]   = 8'(idx);
    assign out_rank[g]  = 8'(rank);
    assign out_count[g] = 8'(cnt);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_state(input int d);
    check_eq("rst_in_ready", in_ready[d], 1);
    check_eq("rst_out_valid", out_valid[d], 0);
    check_eq("rst_out_idx", out_idx[d], 0);
    check_eq("rst_out_rank", out_rank[d], 0);
    check_eq("rst_out_last", out_last[d], 0);
    check_eq("rst_out_count", out_count[d], 0);
    check_eq("rst_none_pulse", none_pulse[d], 0);
  endtask

  // Accept one vector on DUT d and consume all beats; mode 0 = always ready,
  // 1 = ready pattern 1,0,0 with ignored in_valid pulses, 2 = random ready.
  task automatic send(input int d, input logic [63:0] vin, input int mode);
    int n, k, cyc, guard, ph;
    bit r;
    beat_t e;
    logic [63:0] m, v;
    n = NS[d];
    m = (64'd1 << n) - 64'd1;
    v = vin & m;
    guard = 0;
    while (in_ready[d] !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq("ready_before_accept", in_ready[d], 1);
    k = 0;
    for (int i = 0; i < n; i++) k += int'(v[i]);
    sb.delete();
    if (MS[d]) begin
      for (int i = n - 1; i >= 0; i--)
        if (v[i]) begin
          e.idx = i; e.rank = sb.size(); e.last = (sb.size() == k - 1); e.cnt = k;
          sb.push_back(e);
        end
    end else begin
      for (int i = 0; i < n; i++)
        if (v[i]) begin
          e.idx = i; e.rank = sb.size(); e.last = (sb.size() == k - 1); e.cnt = k;
          sb.push_back(e);
        end
    end
    in_valid[d] = 1'b1;
    in_req[d] = v;
    out_ready[d] = 1'b0;
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_req[d] = '0;
    if (k == 0) begin
      check_eq("none_pulse", none_pulse[d], 1);
      check_eq("none_out_valid", out_valid[d], 0);
      check_eq("none_in_ready", in_ready[d], 1);
      @(negedge clk);
      check_eq("none_pulse_clear", none_pulse[d], 0);
      check_eq("none_out_valid2", out_valid[d], 0);
      check_eq("none_in_ready2", in_ready[d], 1);
      return;
    end
    check_eq("first_valid_latency", out_valid[d], 1);
    cyc = 1;
    ph = 0;
    guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (ph % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      ph++;
      out_ready[d] = r;
      if (mode != 0) begin
        in_valid[d] = 1'($urandom_range(0, 1));
        in_req[d] = {$urandom, $urandom} & m;
      end
      e = sb[0];
      check_eq("beat_valid", out_valid[d], 1);
      check_eq("beat_idx", out_idx[d], 64'(e.idx));
      check_eq("beat_rank", out_rank[d], 64'(e.rank));
      check_eq("beat_last", out_last[d], 64'(e.last));
      check_eq("beat_count", out_count[d], 64'(e.cnt));
      if (r) void'(sb.pop_front());
      @(negedge clk);
      cyc++;
      guard++;
    end
    in_valid[d] = 1'b0;
    in_req[d] = '0;
    out_ready[d] = 1'b0;
    check_eq("scoreboard_drained", 64'(sb.size()), 0);
    sb.delete();
    check_eq("in_ready_after", in_ready[d], 1);
    check_eq("out_valid_after", out_valid[d], 0);
    if (mode == 0) check_eq("occupancy_cycles", 64'(cyc), 64'(k + 1));
  endtask

  initial begin
    reset = 1'b1;
    in_valid = '0;
    out_ready = '0;
    for (int d = 0; d < NUM; d++) in_req[d] = '0;
    @(negedge clk);
    for (int d = 0; d < NUM; d++) check_reset_state(d);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NUM; d++) check_reset_state(d);

    send(0, 64'h0A5, 0);
    send(1, 64'h801, 0);
    send(0, 64'h000, 0);
    send(0, 64'hFFF, 1);
    send(1, 64'hFFF, 1);

    // Reset mid-EMIT after two beats of 0x0F0, with a colliding accept/take.
    in_valid[0] = 1'b1;
    in_req[0] = 64'h0F0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    in_req[0] = '0;
    check_eq("rstmid_idx0", out_idx[0], 7);
    @(negedge clk);
    check_eq("rstmid_idx1", out_idx[0], 6);
    @(negedge clk);
    check_eq("rstmid_idx2", out_idx[0], 5);
    reset = 1'b1;
    in_valid[0] = 1'b1;
    in_req[0] = 64'h0FF;
    @(negedge clk);
    check_reset_state(0);
    reset = 1'b0;
    in_valid[0] = 1'b0;
    in_req[0] = '0;
    out_ready[0] = 1'b0;
    @(negedge clk);
    check_reset_state(0);
    out_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("no_stale_beat", out_valid[0], 0);
    end
    out_ready[0] = 1'b0;
    send(0, 64'h001, 0);

    for (int d = 2; d < NUM; d++) begin
      for (int it = 0; it < 25; it++) begin
        logic [63:0] v;
        v = {$urandom, $urandom};
        if (it % 5 == 0) v = 64'd1 << $urandom_range(0, NS[d] - 1);
        if (it == 7) v = '0;
        send(d, v, it % 3);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/priority_request_serializer.md
PRIORITY_REQUEST_SERIALIZER -- requirements
Module: priority_request_serializer

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter N, default 12: request vector width; SHALL be legal for 2..64.
REQ-003 Parameter MSB_FIRST, default 1: 1 = highest set index emitted first; 0 = lowest set index emitted first.
REQ-004 Localparam IDX_W = $clog2(N): width of index and rank outputs.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  in_req is offered.
REQ-008 in_ready  output  1  block can accept a vector this cycle.
REQ-009 in_req  input  N  request vector; bit i = request i.
REQ-010 out_valid  output  1  out_idx/out_rank/out_last/out_count are valid.
REQ-011 out_ready  input  1  consumer accepts the current beat.
REQ-012 out_idx  output  IDX_W  index of the current granted request.
REQ-013 out_rank  output  IDX_W  0 for the first beat of a vector, incrementing per beat.
REQ-014 out_last  output  1  current beat is the final set bit of the vector.
REQ-015 out_count  output  IDX_W+1  population count of the accepted vector, constant for all its beats.
REQ-016 none_pulse  output  1  one-cycle pulse when an all-zero vector is accepted.

Function
REQ-017 State machine SHALL have two states: IDLE and EMIT.
REQ-018 IDLE: in_ready=1, out_valid=0.
REQ-019 EMIT: in_ready=0, out_valid=1; a new vector is never accepted while EMIT is active, including on the cycle its last beat is taken.
REQ-020 Accept = in_valid && in_ready; on accept of a nonzero vector, pending <= in_req, out_count <= popcount(in_req), rank <= 0, state <= EMIT.
REQ-021 On accept of an all-zero vector, the state SHALL remain IDLE and none_pulse SHALL be 1 on the following cycle only.
REQ-022 Latency SHALL be 1 cycle from accept to first out_valid.
REQ-023 out_idx SHALL be the highest set index of pending when MSB_FIRST=1 and the lowest when MSB_FIRST=0.
REQ-024 out_last SHALL be 1 exactly when pending has one bit set.
REQ-025 A beat is taken on out_valid && out_ready; on take, the out_idx bit SHALL be cleared from pending and rank SHALL increment.
REQ-026 If the taken beat has out_last=1, state SHALL go to IDLE, and in_ready SHALL be 1 on the next cycle.
REQ-027 While out_valid=1 and out_ready=0, every output SHALL hold stable (no skipped or changed index).
REQ-028 A full back-to-back throughput of one beat per cycle SHALL be sustained while out_ready=1.
REQ-029 A vector with K set bits SHALL occupy K+1 cycles from accept to the next in_ready (out_ready held 1).
REQ-030 in_valid/in_req SHALL be ignored while in EMIT.

Reset
REQ-031 Reset SHALL force IDLE, pending=0, rank=0, out_count=0, and none_pulse=0.
REQ-032 During reset, and on the cycle following it, the outputs SHALL be in_ready=1, out_valid=0, out_idx=0, out_rank=0, and out_last=0.
REQ-033 Reset asserted mid-EMIT SHALL discard the remaining beats, and no beat of the old vector SHALL appear afterwards.
REQ-034 Reset SHALL take priority over a simultaneous accept or take.

Verification
REQ-035 N=12, MSB_FIRST=1, in_req=12'h0A5, out_ready=1: beats idx 7,5,2,0 / rank 0..3 / last on idx 0 / count 4; in_ready returns after 5 cycles.
REQ-036 N=12, MSB_FIRST=0, in_req=12'h801: beats idx 0 then 11; last=1 on idx 11; count=2.
REQ-037 in_req=12'h000 accepted: none_pulse=1 for exactly one cycle; out_valid stays 0; in_ready stays 1.
REQ-038 in_req=12'hFFF, out_ready toggled 1,0,0,1,...: all 12 indices 11..0 emitted once, each held stable while stalled; in_valid pulses during EMIT ignored.
REQ-039 Reset asserted after second beat of 12'h0F0: next cycle IDLE, in_ready=1, out_valid=0; a new vector 12'h001 then yields a single beat, idx 0, rank 0, last=1.
REQ-040 Random vectors, N=5 and N=33, both modes: beat sequence matches reference sorted set-bit list, count matches popcount.
